spi_master_interface: RTL and testbench

SPI mode-0 master (CPOL=0, CPHA=0), MSB first: the initiator end of the team's SPI slave link. It lets an on-FPGA controller push unsorted words into a sort block over SPI and read back the sorted words, and it also serves as a board-level bench driver for the slave. One start request produces one CS-framed, DATA_WIDTH-bit full-duplex transfer, and a done pulse marks the received word.

---
 rtl/spi_master_interface_pkg.sv | 10 +
 rtl/spi_master_interface_sck_edge_gen.sv | 36 +++
 rtl/spi_master_interface.sv | 107 ++++++++++
 tb/tb_spi_master_interface.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/spi_master_interface_pkg.sv
// Shared types and helpers for the SPI master link.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_master_state_t;

  localparam int SPI_MODE = 0;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/spi_master_interface_sck_edge_gen.sv
// SCK divider: free-runs while run=1, toggles sck on each divider tick when shift_en=1.
module spi_sck_edge_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic not_reset,
  input  logic run,
  input  logic shift_en,
  output logic tick,
  output logic sck,
  output logic rise_strobe,
  output logic fall_strobe
);
  localparam int DW = clog2_min1(CLK_DIV);

  logic [DW-1:0] div_cnt;

  assign tick        = run && (div_cnt == DW'(CLK_DIV - 1));
  assign rise_strobe = tick && shift_en && !sck;
  assign fall_strobe = tick && shift_en && sck;

  always_ff @(posedge clk or posedge not_reset) begin
    if (not_reset) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (rise_strobe || fall_strobe) sck <= ~sck;
    end
  end
endmodule

// File: rtl/spi_master_interface.sv
// SPI mode-0 master, MSB first: one start request yields one CS-framed full-duplex word.
module spi_master_interface
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 4
) (
  input  logic                  clk,
  input  logic                  not_reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_to_send,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_received,
  output logic                  sck,
  output logic                  mosi,
  output logic                  cs,
  input  logic                  miso
);
  localparam int EW = $clog2(2*DATA_WIDTH + 1);
  localparam int GW = clog2_min1(CS_GAP);
  localparam logic [EW-1:0] LAST_EDGE  = EW'(2*DATA_WIDTH);
  localparam logic [EW-1:0] FINAL_FALL = EW'(2*DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_END    = GW'(CS_GAP - 1);

  spi_master_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift;
  logic [EW-1:0] edge_cnt;
  logic [GW-1:0] gap_cnt;
  logic run, shift_en, tick, rise_strobe, fall_strobe;

  // SETUP's last tick is also the first rising edge, so SHIFT ends with a trailing low half-period.
  spi_sck_edge_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk(clk), .not_reset(not_reset), .run(run), .shift_en(shift_en),
    .tick(tick), .sck(sck), .rise_strobe(rise_strobe), .fall_strobe(fall_strobe)
  );

  always_ff @(posedge clk or posedge not_reset) begin
    if (not_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = SETUP;
      SETUP: if (tick) state_d = SHIFT;
      SHIFT: if (tick && edge_cnt == LAST_EDGE) state_d = HOLD;
      HOLD:  if (tick) state_d = GAP;
      GAP:   if (gap_cnt == GAP_END) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run      = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    shift_en = ((state_q == SETUP) || (state_q == SHIFT)) && (edge_cnt != LAST_EDGE);
  end

  always_ff @(posedge clk or posedge not_reset) begin
    if (not_reset) begin
      cs            <= 1'b1;
      mosi          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      data_received <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      edge_cnt      <= '0;
      gap_cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (rise_strobe) rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
      if (rise_strobe || fall_strobe) edge_cnt <= edge_cnt + EW'(1);
      // The final falling edge leaves the LSB on mosi through HOLD.
      if (fall_strobe && edge_cnt != FINAL_FALL) begin
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        mosi     <= tx_shift[DATA_WIDTH-2];
      end
      case (state_q)
        IDLE: begin
          edge_cnt <= '0;
          gap_cnt  <= '0;
          if (start) begin
            tx_shift <= data_to_send;
            mosi     <= data_to_send[DATA_WIDTH-1];
            cs       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        HOLD: if (tick) begin
          cs            <= 1'b1;
          done          <= 1'b1;
          data_received <= rx_shift;
          mosi          <= 1'b0;
          gap_cnt       <= '0;
        end
        GAP: begin
          if (gap_cnt == GAP_END) busy <= 1'b0;
          else                    gap_cnt <= gap_cnt + GW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_interface.sv
// Directed bench for spi_master_interface at default parameters (8-bit, div 4, gap 4).
module tb_spi_master_interface;
  logic clk = 1'b0;
  logic not_reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] data_to_send = 8'h00;
  logic busy, done, sck, mosi, cs, miso;
  logic [7:0] data_received;

  logic loop = 1'b1;
  logic [7:0] slave_tx = 8'h00, slave_sr = 8'h00, slave_rx = 8'h00;
  int cyc = 0, done_cnt = 0, rise_cnt = 0;
  int checks = 0, failures = 0;

  spi_master_interface #(.DATA_WIDTH(8), .CLK_DIV(4), .CS_GAP(4)) dut (
    .clk(clk), .not_reset(not_reset), .start(start), .data_to_send(data_to_send),
    .busy(busy), .done(done), .data_received(data_received),
    .sck(sck), .mosi(mosi), .cs(cs), .miso(miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  always @(posedge sck) if (cs === 1'b0) rise_cnt++;

  // Slave model: presents MSB at cs fall, shifts on sck fall, captures mosi on sck rise.
  assign miso = loop ? mosi : (cs ? 1'bx : slave_sr[7]);
  always @(negedge cs) slave_sr = slave_tx;
  always @(negedge sck) if (!cs) slave_sr = {slave_sr[6:0], 1'b0};
  always @(posedge sck) if (!cs) slave_rx = {slave_rx[6:0], mosi};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] d, output int t);
    @(negedge clk);
    data_to_send = d;
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin c = cyc; break; end
    end
  endtask

  task automatic wait_cs_low(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cs === 1'b0) begin c = cyc; break; end
    end
  endtask

  initial begin
    int t, t_rise, t_fall, d, d1, d2, d3, gb, tf, n0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cs", cs, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", data_received, 0);
    not_reset = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback 0xA5 with frame timing
    pulse_start(8'hA5, t);
    chk("cs_fall_T1", cs, 0);
    chk("busy_T1", busy, 1);
    t_rise = -1;
    for (int i = 0; i < 20; i++) begin
      if (sck === 1'b1) begin t_rise = cyc; break; end
      @(negedge clk);
    end
    t_fall = -1;
    for (int i = 0; i < 20; i++) begin
      if (sck === 1'b0) begin t_fall = cyc; break; end
      @(negedge clk);
    end
    chk("first_rise", t_rise - t, 5);
    chk("half_period", t_fall - t_rise, 4);
    wait_done(d);
    chk("done_latency", d - t, 73);
    chk("loop_a5", data_received, 8'hA5);
    tf = -1;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) begin tf = cyc; break; end
      @(negedge clk);
    end
    chk("busy_fall", tf - d, 4);
    chk("done_cnt_1", done_cnt, 1);

    // Slave model: master sends 0x3C, slave returns 0x20
    loop = 1'b0;
    slave_tx = 8'h20;
    rise_cnt = 0;
    repeat (2) @(negedge clk);
    pulse_start(8'h3C, t);
    wait_done(d);
    chk("slave_rx_master", data_received, 8'h20);
    chk("slave_cap", slave_rx, 8'h3C);
    chk("rise_cnt", rise_cnt, 8);
    loop = 1'b1;
    repeat (10) @(negedge clk);

    // Held start: three back-to-back frames, data changed after each accept
    data_to_send = 8'h01;
    start = 1'b1;
    wait_cs_low(tf);
    data_to_send = 8'h80;
    wait_done(d1);
    chk("b2b_01", data_received, 8'h01);
    gb = 0;
    tf = -1;
    for (int i = 0; i < 20; i++) begin
      if (cs === 1'b0) begin tf = cyc; break; end
      if (cs === 1'b1 && busy === 1'b1) gb++;
      @(negedge clk);
    end
    chk("gap_cs_high_busy", gb, 4);
    chk("next_cs_fall", tf - d1, 5);
    data_to_send = 8'hFF;
    wait_done(d2);
    chk("b2b_80", data_received, 8'h80);
    chk("period_12", d2 - d1, 77);
    wait_cs_low(tf);
    start = 1'b0;
    wait_done(d3);
    chk("b2b_ff", data_received, 8'hFF);
    chk("period_23", d3 - d2, 77);
    repeat (10) @(negedge clk);

    // Start mid-frame and on the done cycle are ignored
    n0 = done_cnt;
    pulse_start(8'h33, t);
    while (cyc < t + 30) @(negedge clk);
    data_to_send = 8'h99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("ignore_done_cnt", done_cnt, n0 + 1);
    chk("ignore_data", data_received, 8'h33);
    chk("ignore_cs_idle", cs, 1);

    // Asynchronous reset mid-frame
    pulse_start(8'hC3, t);
    while (cyc < t + 30) @(negedge clk);
    n0 = done_cnt;
    chk("pre_rst_cs", cs, 0);
    not_reset = 1'b1;
    #1;
    chk("mid_rst_cs", cs, 1);
    chk("mid_rst_sck", sck, 0);
    chk("mid_rst_rx", data_received, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    not_reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_no_done", done_cnt, n0);
    pulse_start(8'h5A, t);
    wait_done(d);
    chk("post_rst_latency", d - t, 73);
    chk("post_rst_5a", data_received, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
